// File: rtl/byte_cmd_sequencer_pkg.sv
// Shared definitions for the byte command sequencer: FSM states, opcode field and word width.
package byte_cmd_sequencer_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned OPC_N_LO = 0;
   localparam int unsigned OPC_N_HI = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_ISSUE   = 2'd2
   } state_e;

   function automatic logic [2:0] opc_nwords(input logic [BYTE_W-1:0] opc);
      return opc[OPC_N_HI:OPC_N_LO];
   endfunction

endpackage

// File: rtl/byte_cmd_sequencer_word_assembler.sv
// Packs bytes MSB-first into 32-bit words; done_o flags the strobe carrying the 4th byte,
// with word_o showing the completed word in that same cycle.
module byte_cmd_sequencer_word_assembler
   import byte_cmd_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              strobe_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic [WORD_W-1:0] word_o,
   output logic              done_o
);

   logic [WORD_W-BYTE_W-1:0] shift_q;
   logic [1:0]               cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (clr_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (strobe_i) begin
         shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_i};
         cnt_q   <= cnt_q + 2'd1;
      end
   end

   // The 4th byte bypasses the register so the sequencer can store the word without a cycle of lag.
   always_comb begin
      word_o = {shift_q, byte_i};
      done_o = strobe_i && !clr_i && (cnt_q == 2'd3);
   end

endmodule

// File: rtl/byte_cmd_sequencer.sv
// Frames opcode + N big-endian argument words from a byte stream and offers them over valid/ready.
// Optional inter-byte timeout in COLLECT is enabled by defining SEQ_TIMEOUT_EN.
module byte_cmd_sequencer
   import byte_cmd_sequencer_pkg::*;
#(
   parameter int unsigned MAX_WORDS      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [BYTE_W-1:0]           current_byte,
   input  logic                        ie,
   output logic                        cmd_valid,
   input  logic                        cmd_ready,
   output logic [BYTE_W-1:0]           cmd_opcode,
   output logic [2:0]                  cmd_nwords,
   output logic [WORD_W*MAX_WORDS-1:0] cmd_words,
   output logic                        busy,
   output logic                        overflow,
   output logic                        bad_opcode,
   output logic                        timeout
);

   localparam logic [3:0] MAXW = 4'(MAX_WORDS);

   state_e              state_q, state_d;
   logic [BYTE_W-1:0]   opcode_q;
   logic [2:0]          nwords_q;
   logic [2:0]          word_idx_q;
   logic [WORD_W-1:0]   words_q [MAX_WORDS];
   logic                overflow_q, bad_q, timeout_q;

   logic [2:0]          op_n;
   logic                op_take, op_bad, op_load, drop;
   logic                asm_strobe, asm_clr, asm_done, last_word, tmo_expire;
   logic [WORD_W-1:0]   asm_word;

   // A byte is treated as an opcode in IDLE, or in ISSUE when the handshake completes in the same cycle.
   always_comb begin
      op_n       = opc_nwords(current_byte);
      op_take    = ie && ((state_q == ST_IDLE) || ((state_q == ST_ISSUE) && cmd_ready));
      op_bad     = op_take && ({1'b0, op_n} > MAXW);
      op_load    = op_take && !op_bad;
      drop       = ie && (state_q == ST_ISSUE) && !cmd_ready;
      asm_strobe = ie && (state_q == ST_COLLECT);
      last_word  = asm_done && (3'(word_idx_q + 3'd1) == nwords_q);
      asm_clr    = op_load || tmo_expire;
   end

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] tmo_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         tmo_cnt_q <= '0;
      else if ((state_q != ST_COLLECT) || ie || tmo_expire)
         tmo_cnt_q <= '0;
      else
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
   end

   always_comb tmo_expire = (state_q == ST_COLLECT) && !ie && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
   always_comb tmo_expire = 1'b0;
`endif

   byte_cmd_sequencer_word_assembler u_asm (
      .clk      (clk),
      .rst_n    (reset),
      .clr_i    (asm_clr),
      .strobe_i (asm_strobe),
      .byte_i   (current_byte),
      .word_o   (asm_word),
      .done_o   (asm_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (op_load) state_d = (op_n == 3'd0) ? ST_ISSUE : ST_COLLECT;
         end
         ST_COLLECT: begin
            if (last_word)       state_d = ST_ISSUE;
            else if (tmo_expire) state_d = ST_IDLE;
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               if (op_load) state_d = (op_n == 3'd0) ? ST_ISSUE : ST_COLLECT;
               else         state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_valid  = (state_q == ST_ISSUE);
      busy       = (state_q != ST_IDLE);
      overflow   = overflow_q;
      bad_opcode = bad_q;
      timeout    = timeout_q;
      cmd_opcode = opcode_q;
      cmd_nwords = nwords_q;
      cmd_words  = '0;
      for (int unsigned k = 0; k < MAX_WORDS; k++)
         cmd_words[k*WORD_W +: WORD_W] = words_q[k];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         opcode_q   <= '0;
         nwords_q   <= '0;
         word_idx_q <= '0;
         overflow_q <= 1'b0;
         bad_q      <= 1'b0;
         timeout_q  <= 1'b0;
         for (int unsigned k = 0; k < MAX_WORDS; k++)
            words_q[k] <= '0;
      end else begin
         overflow_q <= drop;
         bad_q      <= op_bad;
         timeout_q  <= tmo_expire;
         if (op_load) begin
            opcode_q   <= current_byte;
            nwords_q   <= op_n;
            word_idx_q <= '0;
         end else if (asm_done) begin
            word_idx_q <= 3'(word_idx_q + 3'd1);
            for (int unsigned k = 0; k < MAX_WORDS; k++)
               if (word_idx_q == 3'(k)) words_q[k] <= asm_word;
         end
      end
   end

endmodule
